// File: rtl/mem_readback_pkg.sv
// Shared definitions for the memory readback block: memory geometry,
// segment bases and the readback FSM state encoding.
package mem_readback_pkg;

  localparam int RB_ADDR_WIDTH = 13;
  localparam int RB_DATA_WIDTH = 32;

  localparam int MEM_WORDS     = 8192;
  localparam int TEXT_SEG_BASE = 0;
  localparam int DATA_SEG_BASE = 4096;

  typedef enum logic [2:0] {
    RB_IDLE    = 3'd0,
    RB_ISSUE   = 3'd1,
    RB_CAPTURE = 3'd2,
    RB_HOLD    = 3'd3,
    RB_FINISH  = 3'd4
  } rb_state_t;

endpackage

// File: rtl/mem_readback.sv
// Reads a block of words from the unified memory's second read port and
// streams each word out tagged with its address.
//
// Stream handshake: out_valid/out_addr/out_data are held stable from the cycle
// out_valid rises until a clock edge where out_valid && out_ready; that edge
// transfers the word. out_valid never drops without a transfer (except reset).
module mem_readback
  import mem_readback_pkg::*;
#(
  parameter int ADDR_WIDTH = RB_ADDR_WIDTH,
  parameter int DATA_WIDTH = RB_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam logic [ADDR_WIDTH-1:0] CUR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  rb_state_t             state;
  rb_state_t             state_nxt;
  logic [ADDR_WIDTH-1:0] cur;   // address of the word being read/streamed
  logic [ADDR_WIDTH:0]   rem;   // words still to stream, including the current one

  // The read port is driven straight from the FSM; cur is the address register.
  assign mem_rd_en = (state == RB_ISSUE);
  assign mem_addr  = cur;

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RB_IDLE: begin
        if (start) begin
          state_nxt = (word_count != '0) ? RB_ISSUE : RB_FINISH;
        end
      end
      RB_ISSUE:   state_nxt = RB_CAPTURE;
      RB_CAPTURE: state_nxt = RB_HOLD;
      RB_HOLD: begin
        if (out_ready) begin
          state_nxt = (rem > REM_ONE) ? RB_ISSUE : RB_FINISH;
        end
      end
      RB_FINISH:  state_nxt = RB_IDLE;
      default:    state_nxt = RB_IDLE;
    endcase
  end

  // State register, address/remaining counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RB_IDLE;
      cur       <= '0;
      rem       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state <= state_nxt;
      // done lands the cycle after FINISH, the same edge that drops busy.
      done  <= (state == RB_FINISH);
      unique case (state)
        RB_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            cur  <= base_addr;
            rem  <= word_count;
          end
        end
        RB_CAPTURE: begin
          out_data  <= mem_rd_data;
          out_addr  <= cur;
          out_valid <= 1'b1;
        end
        RB_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cur       <= cur + CUR_ONE;
            rem       <= rem - REM_ONE;
          end
        end
        RB_FINISH: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_readback.sv
// Bench for mem_readback: a behavioural memory plus an expected-word queue
// built from the memory contents, base and count of each transfer.
module tb_mem_readback;
  import mem_readback_pkg::*;

  localparam int AW = RB_ADDR_WIDTH;
  localparam int DW = RB_DATA_WIDTH;
  localparam int EW = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          busy, done, mem_rd_en, out_valid, out_ready;
  logic [AW-1:0] mem_addr, out_addr;
  logic [DW-1:0] mem_rd_data, out_data;

  mem_readback dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data)
  );

  // Synchronous-read memory model.
  logic [DW-1:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rd_pulses = 0;
  int done_pulses = 0;
  int hs_count = 0;
  int exp_total = 0;
  logic prev_hold = 1'b0;
  logic [EW-1:0] prev_word = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stream monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        rd_pulses++;
        check("mem_addr_known", 64'($isunknown(mem_addr)), 64'(0));
      end
      if (done) done_pulses++;
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_stable", 64'({out_addr, out_data}), 64'(prev_word));
      end
      if (out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) check("word_overrun", 64'(hs_count), 64'(exp_total));
        else check("word", 64'({out_addr, out_data}), 64'(exp_q.pop_front()));
      end
      prev_hold = out_valid && !out_ready;
      prev_word = {out_addr, out_data};
    end else begin
      prev_hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input int base, input int count);
    logic [AW-1:0] a;
    for (int i = 0; i < count; i++) begin
      a = AW'(base + i);
      exp_q.push_back({a, mem[a]});
    end
    exp_total = hs_count + count;
  endtask

  task automatic check_idle_outputs();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rd_en", 64'(mem_rd_en), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_out_addr", 64'(out_addr), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 5 cycles on word 2.
  task automatic do_xfer(input int base, input int count, input int mode, input bit restart);
    int rd0, dn0, hs0, first_v, done_c, stall, budget;
    @(posedge clk); #1;
    push_expected(base, count);
    rd0 = rd_pulses; dn0 = done_pulses; hs0 = hs_count;
    start      = 1'b1;
    base_addr  = AW'(base);
    word_count = (AW+1)'(count);
    out_ready  = 1'b1;
    first_v = -1; done_c = -1; stall = 0;
    budget = count * 8 + 20;
    for (int n = 1; n <= budget && done_c < 0; n++) begin
      @(posedge clk); #1;
      start      = restart && (n == 4);
      base_addr  = AW'($urandom);
      word_count = (AW+1)'($urandom);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !((hs_count - hs0) == 1 && stall < 5);
      endcase
      @(negedge clk);
      if (n == 1) check("busy_rise", 64'(busy), 64'(1));
      if (!out_ready && out_valid) stall++;
      if (out_valid && first_v < 0) first_v = n;
      if (done && done_c < 0) begin
        done_c = n;
        check("busy_falls_with_done", 64'(busy), 64'(0));
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("done_seen", 64'(done_c > 0), 64'(1));
    if (count > 0) check("first_valid_latency", 64'(first_v), 64'(3));
    else begin
      check("zero_done_latency", 64'(done_c), 64'(2));
      check("zero_no_valid", 64'(first_v), 64'(-1));
    end
    if (mode == 0 && count > 0) check("steady_cycles", 64'(done_c), 64'(3 * count + 2));
    if (mode == 2 && count >= 2) check("stall_cycles", 64'(stall), 64'(5));
    check("rd_pulses", 64'(rd_pulses - rd0), 64'(count));
    check("words", 64'(hs_count - hs0), 64'(count));
    check("done_pulses", 64'(done_pulses - dn0), 64'(1));
    check("exp_empty", 64'(exp_q.size()), 64'(0));
    check("busy_idle", 64'(busy), 64'(0));
    exp_q.delete();
  endtask

  // Reset while holding word 2 of 4: transfer abandoned, no done pulse.
  task automatic reset_mid_transfer();
    int hs0, dn0;
    bit reached;
    @(posedge clk); #1;
    push_expected(DATA_SEG_BASE, 4);
    hs0 = hs_count;
    start = 1'b1; base_addr = AW'(DATA_SEG_BASE); word_count = (AW+1)'(4);
    out_ready = 1'b1;
    reached = 1'b0;
    for (int n = 0; n < 40 && !reached; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = !((hs_count - hs0) >= 1);
      @(negedge clk);
      if ((hs_count - hs0) == 1 && out_valid) reached = 1'b1;
    end
    check("reached_hold_word2", 64'(reached), 64'(1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs();
    reset = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    dn0 = done_pulses;
    repeat (6) @(negedge clk);
    check("no_done_after_reset", 64'(done_pulses - dn0), 64'(0));
    check("idle_after_reset", 64'(busy), 64'(0));
    do_xfer(100, 3, 1, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[DATA_SEG_BASE + 0] = 32'd11;
    mem[DATA_SEG_BASE + 1] = 32'd22;
    mem[DATA_SEG_BASE + 2] = 32'd33;
    mem[DATA_SEG_BASE + 3] = 32'd44;

    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs();
    reset = 1'b0;

    do_xfer(DATA_SEG_BASE, 4, 0, 1'b0);
    do_xfer(DATA_SEG_BASE, 4, 2, 1'b0);
    do_xfer(8190, 3, 0, 1'b0);
    do_xfer(DATA_SEG_BASE, 0, 0, 1'b0);
    reset_mid_transfer();
    do_xfer(DATA_SEG_BASE, 4, 0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      do_xfer(int'($urandom_range(0, MEM_WORDS - 1)), int'($urandom_range(1, 20)),
              1, 1'($urandom_range(0, 1)));
    end
    do_xfer(5000, MEM_WORDS, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
